// File: rtl/moore_ol_pkg.sv
// rtl/moore_ol_pkg.sv - shared state encoding and pattern for the 1101 detector
package moore_ol_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN     = 4'b1101;
    localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/moore_ol.sv
// rtl/moore_ol.sv - overlapping Moore detector for serial pattern 1101, MSB first
module moore_ol
    import moore_ol_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // S4 on a 1 reuses the trailing 1 of the match, giving prefix "11"
    always_comb begin
        w_next_state = S0;
        case (r_state)
            S0:      w_next_state = in ? S1 : S0;
            S1:      w_next_state = in ? S2 : S0;
            S2:      w_next_state = in ? S2 : S3;
            S3:      w_next_state = in ? S4 : S0;
            S4:      w_next_state = in ? S2 : S0;
            default: w_next_state = S0;
        endcase
    end

    always_comb begin
        out = 1'b0;
        if (r_state == S4) begin
            out = 1'b1;
        end
    end

endmodule

// File: tb/tb_moore_ol.sv
// tb/tb_moore_ol.sv - scoreboard bench for the 1101 overlapping detector
module tb_moore_ol;
    import moore_ol_pkg::*;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic in_bit  = 1'b1;
    logic out_bit;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        state_t st;
        logic   o;
    } exp_t;

    exp_t   sb_q[$];
    state_t m_state = S0;
    int     m_det   = 0;
    int     d_det   = 0;

    moore_ol dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_bit),
        .out   (out_bit)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic state_t ref_next(input state_t s, input logic b);
        case (s)
            S0:      return b ? S1 : S0;
            S1:      return b ? S2 : S0;
            S2:      return b ? S2 : S3;
            S3:      return b ? S4 : S0;
            S4:      return b ? S2 : S0;
            default: return S0;
        endcase
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_out"}, 32'(out_bit), 32'(e.o));
            check_eq({tag, "_state"}, 32'(dut.r_state), 32'(e.st));
        end
    endtask

    task automatic drive_bit(input logic b, input string tag);
        exp_t e;
        in_bit  = b;
        m_state = ref_next(m_state, b);
        e.st    = m_state;
        e.o     = (m_state == S4);
        if (e.o) m_det++;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (out_bit === 1'b1) d_det++;
        compare_out(tag);
    endtask

    task automatic drive_seq(input logic [15:0] bits, input int len, input string tag);
        logic [15:0] v;
        v = bits;
        for (int i = len - 1; i >= 0; i--) begin
            drive_bit(v[i], tag);
        end
    endtask

    // Called just after a rising edge so the whole pulse fits before the next one
    task automatic async_reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        check_eq({tag, "_rst_out"}, 32'(out_bit), 32'd0);
        check_eq({tag, "_rst_state"}, 32'(dut.r_state), 32'(S0));
        m_state = S0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] pat;
        int         det_before;

        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("reset_hold_out", 32'(out_bit), 32'd0);
            check_eq("reset_hold_state", 32'(dut.r_state), 32'(S0));
        end
        @(negedge clk);
        reset   = 1'b1;
        m_state = S0;

        pat = PATTERN;
        for (int i = PATTERN_LEN - 1; i >= 0; i--) begin
            drive_bit(pat[i], "single");
        end
        check_eq("single_det_out", 32'(out_bit), 32'd1);
        drive_bit(1'b0, "single_tail");
        check_eq("single_tail_s0", 32'(dut.r_state), 32'(S0));

        det_before = d_det;
        drive_seq(16'b1101101, 7, "overlap");
        check_eq("overlap_count", 32'(d_det - det_before), 32'd2);

        check_eq("s4_before_rst", 32'(out_bit), 32'd1);
        async_reset_pulse("s4_async");

        det_before = d_det;
        drive_seq(16'b111101, 6, "nm_ones");
        check_eq("nm_ones_count", 32'(d_det - det_before), 32'd1);
        drive_bit(1'b0, "nm_ones_tail");

        det_before = d_det;
        drive_seq(16'b101001, 6, "nm_zeros");
        check_eq("nm_zeros_count", 32'(d_det - det_before), 32'd0);

        drive_seq(16'b110, 3, "midrst_pre");
        async_reset_pulse("midrst");
        drive_bit(1'b1, "midrst_first");
        check_eq("midrst_s1", 32'(dut.r_state), 32'(S1));
        drive_seq(16'b101, 3, "midrst_post");
        check_eq("midrst_det", 32'(out_bit), 32'd1);

        m_det = 0;
        d_det = 0;
        for (int i = 0; i < 1000; i++) begin
            drive_bit(1'($urandom_range(0, 1)), "rand");
        end
        check_eq("rand_det_match", 32'(d_det), 32'(m_det));
        check_eq("rand_det_min20", 32'(d_det >= 20), 32'd1);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
